// File: rtl/touch_pkg.sv
// Shared types and constants for the LT24 touch ADC sampler.
// Holds the sampler state enum and the SPI frame geometry.
package touch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONV_X,
    ST_CONV_Y,
    ST_ACCUM,
    ST_CHECK,
    ST_PRESENT
  } state_t;

  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  localparam int FRAME_SCLKS = 24;
  localparam int DATA_FIRST  = 10;
  localparam int DATA_W      = 12;

endpackage

// File: rtl/touch_spi_xfer.sv
// One 24-SCLK ADS7843 frame: sends cmd MSB first, returns 12-bit result.
// Ports: start/cmd in, done pulse + rdata out, spi_sclk/mosi/ss_n/miso.
module touch_spi_xfer
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [7:0]        cmd,
  input  logic              spi_miso,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_ss_n
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HALF_W = $clog2(2 * FRAME_SCLKS + 2);

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] H_TRAIL =
    HALF_W'(2 * FRAME_SCLKS);
  localparam logic [HALF_W-1:0] H_D_FIRST =
    HALF_W'(2 * (DATA_FIRST - 1));
  localparam logic [HALF_W-1:0] H_D_LAST =
    HALF_W'(2 * (DATA_FIRST + DATA_W - 2));

  logic              busy;
  logic [DIV_W-1:0]  div_cnt;
  logic [HALF_W-1:0] half;
  logic [7:0]        sh;
  logic              tick;
  logic              in_data;

  // Half-period index: even halves end in a rise, odd in a fall,
  // H_TRAIL ends with ss_n high, the one after is the idle gap.
  assign tick    = busy && (div_cnt == DIV_LAST);
  assign in_data = !half[0] &&
                   (half >= H_D_FIRST) &&
                   (half <= H_D_LAST);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      busy     <= 1'b0;
      div_cnt  <= '0;
      half     <= '0;
      sh       <= '0;
      done     <= 1'b0;
      rdata    <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_ss_n <= 1'b1;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy     <= 1'b1;
        div_cnt  <= '0;
        half     <= '0;
        spi_ss_n <= 1'b0;
        spi_mosi <= cmd[7];
        sh       <= cmd << 1;
      end else if (busy) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          half <= half + 1'b1;
          if (half < H_TRAIL) begin
            if (!half[0]) begin
              spi_sclk <= 1'b1;
              if (in_data)
                rdata <= {rdata[DATA_W-2:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              spi_mosi <= sh[7];
              sh       <= sh << 1;
            end
          end else if (half == H_TRAIL) begin
            spi_ss_n <= 1'b1;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/touch_panel_sampler.sv
// LT24 touch sampler: pen debounce, X/Y conversions, 2^AVG_LOG2 averaging,
// valid/ready coord output. Macro TOUCH_RANGE_CHECK_EN drops out-of-range pairs.
module touch_panel_sampler
  import touch_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int AVG_LOG2      = 2,
  parameter int SETTLE_CYCLES = 500,
  parameter int RAW_MIN       = 100,
  parameter int RAW_MAX       = 3995
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              pen_irq_n,
  input  logic              spi_miso,
  output logic              spi_mosi,
  output logic              spi_sclk,
  output logic              spi_ss_n,
  output logic [DATA_W-1:0] coord_x,
  output logic [DATA_W-1:0] coord_y,
  output logic              coord_valid,
  input  logic              coord_ready,
  output logic              pen_down
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] PAIRS =
    CNT_W'(1 << AVG_LOG2);
  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'(SETTLE_CYCLES - 1);

  state_t state_q, state_d;

  logic              pen_meta, pen_sync;
  logic [SET_W-1:0]  set_cnt;
  logic [ACC_W-1:0]  acc_x, acc_y;
  logic [CNT_W-1:0]  pair_cnt;
  logic [DATA_W-1:0] raw_x, raw_y;

  logic              xfer_start;
  logic [7:0]        xfer_cmd;
  logic              xfer_done;
  logic [DATA_W-1:0] xfer_rdata;

  logic pen_set, discard, load_out, accept;
  logic keep_pair;

`ifdef TOUCH_RANGE_CHECK_EN
  localparam logic [DATA_W-1:0] R_MIN = DATA_W'(RAW_MIN);
  localparam logic [DATA_W-1:0] R_MAX = DATA_W'(RAW_MAX);
  assign keep_pair = (raw_x >= R_MIN) && (raw_x <= R_MAX) &&
                     (raw_y >= R_MIN) && (raw_y <= R_MAX);
`else
  logic unused_raw;
  assign unused_raw = ^{RAW_MIN, RAW_MAX};
  assign keep_pair  = 1'b1;
`endif

  touch_spi_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .start       (xfer_start),
    .cmd         (xfer_cmd),
    .spi_miso    (spi_miso),
    .done        (xfer_done),
    .rdata       (xfer_rdata),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_ss_n    (spi_ss_n)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    xfer_start = 1'b0;
    xfer_cmd   = CMD_X;
    pen_set    = 1'b0;
    discard    = 1'b0;
    load_out   = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!pen_sync) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (pen_sync) begin
          state_d = ST_IDLE;
        end else if (set_cnt >= SET_LAST) begin
          state_d    = ST_CONV_X;
          xfer_start = 1'b1;
          pen_set    = 1'b1;
        end
      end
      ST_CONV_X: begin
        if (xfer_done) begin
          state_d    = ST_CONV_Y;
          xfer_start = 1'b1;
          xfer_cmd   = CMD_Y;
        end
      end
      ST_CONV_Y: begin
        if (xfer_done) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (pen_sync) begin
          state_d = ST_IDLE;
          discard = 1'b1;
        end else if (pair_cnt < PAIRS) begin
          state_d    = ST_CONV_X;
          xfer_start = 1'b1;
        end else begin
          state_d  = ST_PRESENT;
          load_out = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (coord_ready) begin
          state_d = ST_CHECK;
          accept  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pen level only advances between frames, so ADC switching
  // noise on pen_irq_n during a conversion is never seen.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pen_meta    <= 1'b1;
      pen_sync    <= 1'b1;
      set_cnt     <= '0;
      pen_down    <= 1'b0;
      raw_x       <= '0;
      raw_y       <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      pair_cnt    <= '0;
      coord_x     <= '0;
      coord_y     <= '0;
      coord_valid <= 1'b0;
    end else begin
      pen_meta <= pen_irq_n;
      if (spi_ss_n) pen_sync <= pen_meta;

      set_cnt <= (state_d == ST_SETTLE) ?
                 set_cnt + 1'b1 : '0;

      if (pen_set)      pen_down <= 1'b1;
      else if (discard) pen_down <= 1'b0;

      if (xfer_done && state_q == ST_CONV_X)
        raw_x <= xfer_rdata;
      if (xfer_done && state_q == ST_CONV_Y)
        raw_y <= xfer_rdata;

      if (discard || accept) begin
        acc_x    <= '0;
        acc_y    <= '0;
        pair_cnt <= '0;
      end else if (state_q == ST_ACCUM && keep_pair) begin
        acc_x    <= acc_x + ACC_W'(raw_x);
        acc_y    <= acc_y + ACC_W'(raw_y);
        pair_cnt <= pair_cnt + 1'b1;
      end

      // Top DATA_W bits of the sum are the truncated average.
      if (load_out) begin
        coord_x     <= acc_x[ACC_W-1 -: DATA_W];
        coord_y     <= acc_y[ACC_W-1 -: DATA_W];
        coord_valid <= 1'b1;
      end else if (accept) begin
        coord_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_touch_panel_sampler.sv
// Bench for touch_panel_sampler: ADC model, averaging reference,
// scoreboard monitor and directed pen/reset/backpressure scenarios.
module tb_touch_panel_sampler;

  localparam int CLK_DIV = 4;
  localparam int AVG_L2  = 2;
  localparam int NAVG    = 1 << AVG_L2;
  localparam int R_MIN   = 100;
  localparam int R_MAX   = 3995;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        pen_irq_n;
  logic        spi_miso;
  logic        coord_ready;
  logic        spi_mosi, spi_sclk, spi_ss_n;
  logic [11:0] coord_x, coord_y;
  logic        coord_valid, pen_down;

  always #5 clk_clk = ~clk_clk;

  touch_panel_sampler #(
    .CLK_DIV       (CLK_DIV),
    .AVG_LOG2      (AVG_L2),
    .SETTLE_CYCLES (500),
    .RAW_MIN       (R_MIN),
    .RAW_MAX       (R_MAX)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .pen_irq_n   (pen_irq_n),
    .spi_miso    (spi_miso),
    .spi_mosi    (spi_mosi),
    .spi_sclk    (spi_sclk),
    .spi_ss_n    (spi_ss_n),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .coord_valid (coord_valid),
    .coord_ready (coord_ready),
    .pen_down    (pen_down)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference model state
  logic [11:0] dir_x[$];
  logic [11:0] dir_y[$];
  logic [23:0] exp_q[$];
  int          sum_x, sum_y, npairs;
  logic [11:0] cur_x;
  logic [11:0] adc_val;
  logic [7:0]  adc_cmd;
  logic [7:0]  exp_cmd = 8'hD0;
  int          rises = 0;
  int          frames = 0;
  int          out_count = 0;
  bit          rnd_ready = 1'b0;
  bit          ready_force = 1'b1;

  function automatic void model_clear();
    sum_x  = 0;
    sum_y  = 0;
    npairs = 0;
    exp_q.delete();
  endfunction

  function automatic void add_pair(input int x, input int y);
`ifdef TOUCH_RANGE_CHECK_EN
    if (x < R_MIN || x > R_MAX || y < R_MIN || y > R_MAX)
      return;
`endif
    sum_x += x;
    sum_y += y;
    npairs++;
    if (npairs == NAVG) begin
      exp_q.push_back({12'(sum_x / NAVG),
                       12'(sum_y / NAVG)});
      sum_x  = 0;
      sum_y  = 0;
      npairs = 0;
    end
  endfunction

  // ADC model: decodes the command, serves a code per frame
  always @(negedge spi_ss_n) begin
    rises = 0;
    frames++;
  end

  always @(posedge spi_sclk) begin
    rises++;
    if (rises <= 8) adc_cmd = {adc_cmd[6:0], spi_mosi};
    if (rises == 8) begin
      chk("mosi_cmd", 32'(adc_cmd), 32'(exp_cmd));
      exp_cmd = (exp_cmd == 8'hD0) ? 8'h90 : 8'hD0;
      if (adc_cmd == 8'hD0) begin
        adc_val = (dir_x.size() != 0) ? dir_x.pop_front()
                : 12'($urandom_range(4095, 0));
        cur_x = adc_val;
      end else begin
        adc_val = (dir_y.size() != 0) ? dir_y.pop_front()
                : 12'($urandom_range(4095, 0));
        add_pair(int'(cur_x), int'(adc_val));
      end
    end
  end

  always @(negedge spi_sclk) begin
    int nx;
    nx = rises + 1;
    if (nx >= 10 && nx <= 21) spi_miso = adc_val[21 - nx];
    else                      spi_miso = 1'b0;
  end

  always @(posedge spi_ss_n) begin
    if (!reset_reset)
      chk("sclk_rises_per_frame", 32'(rises), 32'd24);
  end

  // Scoreboard monitor
  always @(negedge clk_clk) begin
    logic [23:0] e;
    if (!reset_reset && coord_valid && coord_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: x=%h y=%h none expected",
                 coord_x, coord_y);
      end else begin
        e = exp_q.pop_front();
        chk("coord_x", 32'(coord_x), 32'(e[23:12]));
        chk("coord_y", 32'(coord_y), 32'(e[11:0]));
      end
      out_count++;
    end
  end

  initial begin
    forever begin
      @(posedge clk_clk);
      #1;
      coord_ready = rnd_ready ? ($urandom_range(3, 0) != 0)
                              : ready_force;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic wait_out(input int n, input int budget,
                          input string name);
    int target;
    target = out_count + n;
    for (int i = 0; i < budget && out_count < target; i++)
      cyc(1);
    checks++;
    if (out_count < target) begin
      errors++;
      $display("FAIL %s: %0d outputs seen, %0d required",
               name, out_count, target);
    end
  endtask

  task automatic wait_frame(input int f, input int r,
                            input string name);
    int i;
    for (i = 0; i < 8000; i++) begin
      if (frames >= f && rises >= r) break;
      cyc(1);
    end
    chk(name, 32'(i < 8000), 32'd1);
  endtask

  task automatic restart();
    reset_reset = 1'b1;
    cyc(2);
    model_clear();
    dir_x.delete();
    dir_y.delete();
    exp_cmd = 8'hD0;
    frames = 0;
    reset_reset = 1'b0;
  endtask

  initial begin
    bit          bad;
    logic [11:0] hx, hy;
    int          i;
    logic [11:0] t2x [4];

    reset_reset = 1'b1;
    pen_irq_n   = 1'b1;
    model_clear();
    cyc(3);
    chk("rst_ss_n", 32'(spi_ss_n), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_valid", 32'(coord_valid), 32'd0);
    chk("rst_coord_x", 32'(coord_x), 32'd0);
    chk("rst_coord_y", 32'(coord_y), 32'd0);
    chk("rst_pen_down", 32'(pen_down), 32'd0);
    reset_reset = 1'b0;
    cyc(5);

    // Press one cycle short of the settle time
    pen_irq_n = 1'b0;
    cyc(499);
    pen_irq_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if (!spi_ss_n || pen_down) bad = 1'b1;
      cyc(1);
    end
    chk("short_press_quiet", 32'(bad), 32'd0);
    cyc(10);

    // Constant codes
    for (int k = 0; k < 4; k++) begin
      dir_x.push_back(12'h800);
      dir_y.push_back(12'h400);
    end
    pen_irq_n = 1'b0;
    for (i = 0; i < 700 && !pen_down; i++) cyc(1);
    chk("pen_down_after_settle", 32'(pen_down), 32'd1);
    wait_out(1, 6000, "const_avg");

    // Truncating average
    restart();
    t2x = '{12'h7FF, 12'h801, 12'h800, 12'h802};
    for (int k = 0; k < 4; k++) begin
      dir_x.push_back(t2x[k]);
      dir_y.push_back(12'($urandom_range(4095, 0)));
    end
    wait_out(1, 6000, "trunc_avg");

    // Random codes with random backpressure
    rnd_ready = 1'b1;
    wait_out(8, 30000, "random_avg");
    rnd_ready   = 1'b0;
    ready_force = 1'b0;
    cyc(2);

    // Held output under backpressure
    for (i = 0; i < 6000 && !coord_valid; i++) cyc(1);
    chk("hold_valid_seen", 32'(coord_valid), 32'd1);
    hx = coord_x;
    hy = coord_y;
    bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      cyc(1);
      if (!coord_valid || coord_x != hx ||
          coord_y != hy || !spi_ss_n) bad = 1'b1;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    ready_force = 1'b1;
    for (i = 0; i < 10; i++) begin
      @(negedge clk_clk);
      if (coord_valid && coord_ready) break;
    end
    @(posedge clk_clk);
    #1;
    chk("valid_drop_after_accept", 32'(coord_valid), 32'd0);
    for (i = 0; i < 50 && spi_ss_n; i++) cyc(1);
    chk("frame_after_accept", 32'(spi_ss_n), 32'd0);

    // Pen released during pair 2
    restart();
    wait_frame(4, 12, "reach_pair2");
    pen_irq_n = 1'b1;
    sum_x  = 0;
    sum_y  = 0;
    npairs = 0;
    for (i = 0; i < 400 && !spi_ss_n; i++) cyc(1);
    cyc(30);
    chk("release_pen_down", 32'(pen_down), 32'd0);
    chk("release_valid", 32'(coord_valid), 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!spi_ss_n) bad = 1'b1;
      cyc(1);
    end
    chk("release_no_frame", 32'(bad), 32'd0);
    pen_irq_n = 1'b0;
    wait_out(1, 6000, "after_release");

    // Reset in the middle of a frame
    restart();
    wait_frame(2, 12, "reach_mid_frame");
    reset_reset = 1'b1;
    cyc(1);
    chk("midrst_ss_n", 32'(spi_ss_n), 32'd1);
    chk("midrst_sclk", 32'(spi_sclk), 32'd0);
    chk("midrst_mosi", 32'(spi_mosi), 32'd0);
    chk("midrst_valid", 32'(coord_valid), 32'd0);
    chk("midrst_pen_down", 32'(pen_down), 32'd0);
    model_clear();
    exp_cmd = 8'hD0;
    reset_reset = 1'b0;
    wait_out(1, 6000, "after_mid_reset");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
